branch_predictor: RTL

Dynamic branch direction predictor for the five-stage pipeline. It replaces the fixed always-not-taken prediction with a direct-mapped table of 2-bit saturating counters. Decode looks the table up for conditional branches, and the execute stage writes back the resolved outcome. A post-reset initialisation sequencer walks the table, and saturating statistics counters expose branch and mispredict totals to the debug path.

---
 rtl/branch_predictor.sv | 95 +++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped 2-bit saturating-counter branch direction predictor
module branch_predictor #(
  parameter int         INDEX_BITS  = 6,
  parameter logic [1:0] INIT_STATE  = 2'b01,
  parameter int         COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   lookup_valid,
  input  logic [31:0]            lookup_pc,
  output logic                   pred_taken,
  input  logic                   update_valid,
  input  logic [31:0]            update_pc,
  input  logic                   update_taken,
  input  logic                   update_pred,
  output logic                   init_busy,
  output logic [COUNT_WIDTH-1:0] branch_count,
  output logic [COUNT_WIDTH-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  typedef enum logic {INIT, READY} state_t;

  state_t                state;
  logic [INDEX_BITS-1:0] init_ptr;
  logic [1:0]            counters [ENTRIES];

  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] update_idx;
  logic [1:0]            cur_count;
  logic [1:0]            next_count;
  logic                  accept;
  logic                  unused_pc_bits;

  // Word-aligned PCs: drop the byte offset, no tag, so aliasing PCs share an entry.
  assign lookup_idx = lookup_pc[INDEX_BITS+1:2];
  assign update_idx = update_pc[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0],
                            update_pc[31:INDEX_BITS+2], update_pc[1:0]};

  assign init_busy  = (state == INIT);
  assign accept     = update_valid & ~init_busy;
  assign pred_taken = lookup_valid & ~init_busy & counters[lookup_idx][1];

  // Saturating step of the addressed counter toward the resolved direction.
  always_comb begin
    cur_count  = counters[update_idx];
    next_count = cur_count;
    if (update_taken) begin
      if (cur_count != 2'b11) next_count = cur_count + 2'd1;
    end else begin
      if (cur_count != 2'b00) next_count = cur_count - 2'd1;
    end
  end

  // Init sequencer: sweep every entry once after reset, then stay READY.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      init_ptr <= '0;
    end else begin
      case (state)
        INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == {INDEX_BITS{1'b1}}) state <= READY;
        end
        READY:   state <= READY;
        default: state <= INIT;
      endcase
    end
  end

  // Counter table: init writes own the table until READY, then resolved branches train it.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      counters[init_ptr] <= INIT_STATE;
    end else if (accept) begin
      counters[update_idx] <= next_count;
    end
  end

  // Statistics: saturate at all-ones rather than wrap so debug never sees a small bogus count.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (accept) begin
      if (branch_count != {COUNT_WIDTH{1'b1}}) branch_count <= branch_count + 1'b1;
      if ((update_pred != update_taken) && (mispredict_count != {COUNT_WIDTH{1'b1}}))
        mispredict_count <= mispredict_count + 1'b1;
    end
  end

endmodule
